// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared SPU op-layer definitions.
//   sel_bits()    : selector width for an N-way select/demux (never below 1)
//   demux_ctrl_t  : control half of a demux request {clear, valid}; the
//                   width-dependent sel/data fields are appended by each
//                   user, since a package cannot carry module parameters.
package elixirchip_es1_spu_pkg;

  function automatic int unsigned sel_bits(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

  typedef struct packed {
    logic clear;
    logic valid;
  } demux_ctrl_t;

endpackage

// File: rtl/elixirchip_es1_spu_op_demux_delay.sv
// Clock-enabled register chain of STAGES stages for the demux request path.
//   clk_i   : clock
//   rst_ni  : asynchronous reset, active-low; clears every stage to zero
//   cke_i   : clock enable; 0 freezes the whole chain
//   data_i  : request entering the chain
//   data_o  : request after STAGES cke-qualified edges (combinational when 0)
module elixirchip_es1_spu_op_demux_delay #(
  parameter int unsigned STAGES = 0,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cke_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, cke_i};
    assign data_o      = data_i;
  end else begin : g_chain
    logic [STAGES-1:0][WIDTH-1:0] pipe_d, pipe_q;

    always_comb begin
      pipe_d = pipe_q;
      if (cke_i) begin
        pipe_d[0] = data_i;
        for (int unsigned i = 1; i < STAGES; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    // An all-zero request has clear=0/valid=0, so reset drops in-flight writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign data_o = pipe_q[STAGES-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_demux.sv
// N-way write-side demultiplexer for the SPU op layer (inverse of op_sel).
// One s_data word is routed into lane register m_data[s_sel]; other lanes hold.
//   reset_n : asynchronous reset, active-low; lanes load CLEAR_DATA
//   clk     : clock
//   cke     : clock enable; 0 freezes all state including m_valid
//   s_sel   : destination lane index
//   s_data  : write data
//   s_clear : load CLEAR_DATA into every lane (wins over s_valid)
//   s_valid : write request
//   m_data  : lane registers
//   m_valid : one-hot per-lane write pulse, aligned with the m_data update
module elixirchip_es1_spu_op_demux
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned N          = 4,
  parameter int unsigned SEL_BITS   = sel_bits(N),
  parameter type         sel_t      = logic [SEL_BITS-1:0],
  parameter int unsigned DATA_BITS  = 8,
  parameter type         data_t     = logic [DATA_BITS-1:0],
  parameter data_t       CLEAR_DATA = '1,
  parameter bit          USE_CLEAR  = 1'b1,
  parameter bit          USE_VALID  = 1'b1,
  parameter string       DEVICE     = "RTL",
  parameter string       SIMULATION = "false",
  parameter string       DEBUG      = "false"
) (
  input  logic            reset_n,
  input  logic            clk,
  input  logic            cke,
  input  sel_t            s_sel,
  input  data_t           s_data,
  input  logic            s_clear,
  input  logic            s_valid,
  output data_t [N-1:0]   m_data,
  output logic  [N-1:0]   m_valid
);

  // Elaboration-time parameter sanity checks.
  if (LATENCY < 1) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_demux: LATENCY must be >= 1");
  end
  if (N < 2) begin : g_bad_n
    $error("elixirchip_es1_spu_op_demux: N must be >= 2");
  end
  if (DEVICE == "") begin : g_bad_device
    $error("elixirchip_es1_spu_op_demux: DEVICE must not be empty");
  end
  if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_sim
    $error("elixirchip_es1_spu_op_demux: SIMULATION must be \"true\" or \"false\"");
  end
  if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
    $error("elixirchip_es1_spu_op_demux: DEBUG must be \"true\" or \"false\"");
  end

  typedef struct packed {
    demux_ctrl_t ctrl;
    sel_t        sel;
    data_t       data;
  } req_t;

  req_t s_req;
  req_t d_req;

  always_comb begin
    s_req.ctrl.clear = USE_CLEAR ? s_clear : 1'b0;
    s_req.ctrl.valid = USE_VALID ? s_valid : 1'b1;
    s_req.sel        = s_sel;
    s_req.data       = s_data;
  end

  // LATENCY-1 delay stages; the lane registers below provide the last stage.
  elixirchip_es1_spu_op_demux_delay #(
    .STAGES (LATENCY - 1),
    .WIDTH  ($bits(req_t))
  ) u_delay (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .cke_i  (cke),
    .data_i (s_req),
    .data_o (d_req)
  );

  data_t [N-1:0] m_data_d, m_data_q;
  logic  [N-1:0] m_valid_d, m_valid_q;

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    if (cke) begin
      m_valid_d = '0;
      if (d_req.ctrl.clear) begin
        m_data_d = {N{CLEAR_DATA}};
      end else if (d_req.ctrl.valid) begin
        // Compare against each lane index so an out-of-range sel (N not a
        // power of two) matches nothing instead of indexing past the array.
        for (int unsigned i = 0; i < N; i++) begin
          if (32'(d_req.sel) == i) begin
            m_data_d[i]  = d_req.data;
            m_valid_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data_q  <= {N{CLEAR_DATA}};
      m_valid_q <= '0;
    end else begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_demux.sv
// Directed and model-checked bench for elixirchip_es1_spu_op_demux.
// Three instances share one input bus: LATENCY=1/N=4, LATENCY=3/N=4, LATENCY=1/N=3.
module tb_elixirchip_es1_spu_op_demux;

  logic       clk;
  logic       reset_n;
  logic       cke;
  logic [1:0] s_sel;
  logic [7:0] s_data;
  logic       s_clear;
  logic       s_valid;

  logic [3:0][7:0] md_l1;
  logic [3:0]      mv_l1;
  logic [3:0][7:0] md_l3;
  logic [3:0]      mv_l3;
  logic [2:0][7:0] md_n3;
  logic [2:0]      mv_n3;

  int n_checks;
  int n_fail;

  elixirchip_es1_spu_op_demux #(
    .LATENCY (1),
    .N       (4)
  ) dut_l1 (
    .reset_n (reset_n),
    .clk     (clk),
    .cke     (cke),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .s_clear (s_clear),
    .s_valid (s_valid),
    .m_data  (md_l1),
    .m_valid (mv_l1)
  );

  elixirchip_es1_spu_op_demux #(
    .LATENCY (3),
    .N       (4)
  ) dut_l3 (
    .reset_n (reset_n),
    .clk     (clk),
    .cke     (cke),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .s_clear (s_clear),
    .s_valid (s_valid),
    .m_data  (md_l3),
    .m_valid (mv_l3)
  );

  elixirchip_es1_spu_op_demux #(
    .LATENCY (1),
    .N       (3)
  ) dut_n3 (
    .reset_n (reset_n),
    .clk     (clk),
    .cke     (cke),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .s_clear (s_clear),
    .s_valid (s_valid),
    .m_data  (md_n3),
    .m_valid (mv_n3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       c;
    logic       v;
    logic [1:0] s;
    logic [7:0] d;
  } mreq_t;

  task automatic drive(input logic clr, input logic v, input logic [1:0] sel,
                       input logic [7:0] d);
    s_clear = clr;
    s_valid = v;
    s_sel   = sel;
    s_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference lane behaviour for an n-lane demux given one delayed request.
  function automatic void lane_model(input int unsigned n, input mreq_t r,
                                     inout logic [3:0][7:0] md, inout logic [3:0] mv);
    mv = 4'b0000;
    if (r.c) begin
      for (int unsigned i = 0; i < n; i++) md[i] = 8'hFF;
    end else if (r.v && (32'(r.s) < n)) begin
      md[r.s] = r.d;
      mv[r.s] = 1'b1;
    end
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    cke     = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    repeat (3) step();
    n_checks++;
    if (md_l1 !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL reset_l1_data: got %h expected ffffffff", md_l1);
    end
    n_checks++;
    if (mv_l1 !== 4'b0000) begin
      n_fail++; $display("FAIL reset_l1_valid: got %b expected 0000", mv_l1);
    end
    n_checks++;
    if (md_l3 !== 32'hFFFF_FFFF || mv_l3 !== 4'b0000) begin
      n_fail++; $display("FAIL reset_l3: got %h/%b expected ffffffff/0000", md_l3, mv_l3);
    end
    n_checks++;
    if (md_n3 !== 24'hFF_FFFF || mv_n3 !== 3'b000) begin
      n_fail++; $display("FAIL reset_n3: got %h/%b expected ffffff/000", md_n3, mv_n3);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_walk();
    logic [3:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'(i), 8'h10 + 8'(i));
      step();
      exp_v = 4'b0001 << i;
      n_checks++;
      if (mv_l1 !== exp_v || md_l1[i] !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL walk_lane%0d: got valid %b data %h expected %b %h",
                 i, mv_l1, md_l1[i], exp_v, 8'h10 + 8'(i));
      end
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    step();
    n_checks++;
    if (md_l1 !== 32'h1312_1110 || mv_l1 !== 4'b0000) begin
      n_fail++; $display("FAIL walk_final: got %h/%b expected 13121110/0000", md_l1, mv_l1);
    end
  endtask

  task automatic test_clear();
    drive(1'b1, 1'b1, 2'd2, 8'h55);
    step();
    n_checks++;
    if (md_l1 !== 32'hFFFF_FFFF || mv_l1 !== 4'b0000) begin
      n_fail++; $display("FAIL clear_priority: got %h/%b expected ffffffff/0000", md_l1, mv_l1);
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    step();
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'(i), 8'hA0 + 8'(i));
      step();
    end
    n_checks++;
    if (md_n3 !== 24'hA2_A1A0 || mv_n3 !== 3'b100) begin
      n_fail++; $display("FAIL oor_setup: got %h/%b expected a2a1a0/100", md_n3, mv_n3);
    end
    drive(1'b0, 1'b1, 2'd3, 8'h77);
    step();
    n_checks++;
    if (md_n3 !== 24'hA2_A1A0 || mv_n3 !== 3'b000) begin
      n_fail++; $display("FAIL oor_sel3: got %h/%b expected a2a1a0/000", md_n3, mv_n3);
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 2'd2, 8'h01);
    step();
    n_checks++;
    if (mv_l1 !== 4'b0100 || md_l1[2] !== 8'h01) begin
      n_fail++; $display("FAIL b2b_first: got %b/%h expected 0100/01", mv_l1, md_l1[2]);
    end
    drive(1'b0, 1'b1, 2'd2, 8'h02);
    step();
    n_checks++;
    if (mv_l1 !== 4'b0100 || md_l1[2] !== 8'h02) begin
      n_fail++; $display("FAIL b2b_second: got %b/%h expected 0100/02", mv_l1, md_l1[2]);
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    step();
    n_checks++;
    if (mv_l1 !== 4'b0000 || md_l1[2] !== 8'h02) begin
      n_fail++; $display("FAIL b2b_idle: got %b/%h expected 0000/02", mv_l1, md_l1[2]);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    step();
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    step();
    step();
    n_checks++;
    if (md_l3 !== 32'hFFFF_FFFF || mv_l3 !== 4'b0000) begin
      n_fail++; $display("FAIL stall_clear_l3: got %h/%b expected ffffffff/0000", md_l3, mv_l3);
    end
    drive(1'b0, 1'b1, 2'd1, 8'hA5);
    step();
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    step();
    n_checks++;
    if (md_l3[1] !== 8'hFF || mv_l3 !== 4'b0000) begin
      n_fail++; $display("FAIL stall_early: got %h/%b expected ff/0000", md_l3[1], mv_l3);
    end
    cke = 1'b0;
    repeat (5) step();
    n_checks++;
    if (md_l3[1] !== 8'hFF || mv_l3 !== 4'b0000) begin
      n_fail++; $display("FAIL stall_frozen: got %h/%b expected ff/0000", md_l3[1], mv_l3);
    end
    cke = 1'b1;
    step();
    n_checks++;
    if (md_l3[1] !== 8'hA5 || mv_l3 !== 4'b0010) begin
      n_fail++; $display("FAIL stall_third_edge: got %h/%b expected a5/0010", md_l3[1], mv_l3);
    end
    cke = 1'b0;
    repeat (5) step();
    n_checks++;
    if (mv_l3 !== 4'b0010) begin
      n_fail++; $display("FAIL stall_valid_hold: got %b expected 0010", mv_l3);
    end
    cke = 1'b1;
    step();
    n_checks++;
    if (mv_l3 !== 4'b0000 || md_l3[1] !== 8'hA5) begin
      n_fail++; $display("FAIL stall_release: got %h/%b expected a5/0000", md_l3[1], mv_l3);
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b0, 1'b1, 2'd3, 8'h3C);
    step();
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (md_l3 !== 32'hFFFF_FFFF || mv_l3 !== 4'b0000) begin
      n_fail++; $display("FAIL midflight_async: got %h/%b expected ffffffff/0000", md_l3, mv_l3);
    end
    step();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step();
    n_checks++;
    if (md_l3 !== 32'hFFFF_FFFF || mv_l3 !== 4'b0000) begin
      n_fail++; $display("FAIL midflight_lost: got %h/%b expected ffffffff/0000", md_l3, mv_l3);
    end
  endtask

  // Starts from the fully reset state left by test_reset_midflight.
  task automatic test_random();
    logic [3:0][7:0] e_l1, e_l3, e_n3;
    logic [3:0]      v_l1, v_l3, v_n3;
    mreq_t           p0, p1, r;
    e_l1 = '1; e_l3 = '1; e_n3 = '1;
    v_l1 = '0; v_l3 = '0; v_n3 = '0;
    p0 = '0; p1 = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      cke = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 8'($urandom));
      r = '{c: s_clear, v: s_valid, s: s_sel, d: s_data};
      step();
      if (cke) begin
        lane_model(4, r, e_l1, v_l1);
        lane_model(3, r, e_n3, v_n3);
        lane_model(4, p1, e_l3, v_l3);
        p1 = p0;
        p0 = r;
      end
      n_checks++;
      if (md_l1 !== e_l1 || mv_l1 !== v_l1) begin
        n_fail++;
        $display("FAIL rand_l1 cyc %0d: got %h/%b expected %h/%b", cyc, md_l1, mv_l1, e_l1, v_l1);
      end
      n_checks++;
      if (md_l3 !== e_l3 || mv_l3 !== v_l3) begin
        n_fail++;
        $display("FAIL rand_l3 cyc %0d: got %h/%b expected %h/%b", cyc, md_l3, mv_l3, e_l3, v_l3);
      end
      n_checks++;
      if (md_n3 !== e_n3[2:0] || mv_n3 !== v_n3[2:0]) begin
        n_fail++;
        $display("FAIL rand_n3 cyc %0d: got %h/%b expected %h/%b",
                 cyc, md_n3, mv_n3, e_n3[2:0], v_n3[2:0]);
      end
      n_checks++;
      if ($countones(mv_l1) > 1 || $countones(mv_l3) > 1 || $countones(mv_n3) > 1) begin
        n_fail++;
        $display("FAIL rand_onehot cyc %0d: got %b %b %b expected at most one bit each",
                 cyc, mv_l1, mv_l3, mv_n3);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_walk();
    test_clear();
    test_out_of_range();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
